// File: rtl/node_output_capture.sv
// Capture stage after the node-1 output synchronizer: pushes each change of node_out into a
// show-ahead FIFO with class tag and sticky overflow. Optional macro NODE_OUT_TIMESTAMP_EN adds per-entry stamps.
module node_output_capture #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [15:0]   node_out,
  input  logic          capture_en,
  input  logic          rd_req,
  input  logic          clr_ovf,
  output logic [15:0]   rd_data,
  output logic          rd_kind,
  output logic          rd_valid,
  output logic [AW:0]   level,
  output logic          overflow
`ifdef NODE_OUT_TIMESTAMP_EN
  ,
  output logic [15:0]   rd_stamp
`endif
);

  localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_LVL  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [15:0]   prev_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          ovf_q, ovf_d;
  logic [16:0]   mem_q [DEPTH];
  logic [16:0]   head;

  logic push_req, pop, full, push_ok, drop, kind;

  assign kind     = (node_out[11:8] == 4'h2);
  assign push_req = capture_en && (node_out != prev_q);
  assign full     = (level_q == FULL_LVL);
  assign pop      = rd_req && (level_q != '0);
  // A full FIFO still accepts a push when the same edge frees a slot.
  assign push_ok  = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ONE_PTR;
    if (pop)     rd_ptr_d = rd_ptr_q + ONE_PTR;
    if (push_ok && !pop)      level_d = level_q + ONE_LVL;
    else if (pop && !push_ok) level_d = level_q - ONE_LVL;
    if (drop)         ovf_d = 1'b1;
    else if (clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q   <= 16'h0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      prev_q   <= node_out;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {kind, node_out};
  end

  assign head     = mem_q[rd_ptr_q];
  assign rd_valid = (level_q != '0);
  assign rd_data  = rd_valid ? head[15:0] : 16'h0000;
  assign rd_kind  = rd_valid ? head[16] : 1'b0;
  assign level    = level_q;
  assign overflow = ovf_q;

`ifdef NODE_OUT_TIMESTAMP_EN
  logic [15:0] ts_q;
  logic [15:0] stamp_q [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) ts_q <= 16'h0000;
    else        ts_q <= ts_q + 16'h0001;
  end

  always_ff @(posedge clk) begin
    if (push_ok) stamp_q[wr_ptr_q] <= ts_q;
  end

  assign rd_stamp = rd_valid ? stamp_q[rd_ptr_q] : 16'h0000;
`endif

endmodule
